// File: rtl/game_round_ctrl.sv
// Round sequencer for the shooting game: start detection, target load, aim/timeout, judge, score.
// Optional build macro HIT_TOLERANCE_EN widens a hit to +/-1 column on the X axis.
module game_round_ctrl #(
  parameter int ROUNDS        = 8,
  parameter int TIMEOUT_TICKS = 15,
  parameter int SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ena,
  input  logic               start_btn,
  input  logic               tick,
  input  logic               shot_fire,
  input  logic [4:0]         shot_x,
  input  logic [4:0]         shot_y,
  input  logic [4:0]         target_x,
  input  logic [4:0]         target_y,
  output logic               start_new_game,
  output logic               result_valid,
  output logic               hit,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         round_cnt,
  output logic               busy,
  output logic               game_over
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    AIM,
    JUDGE,
    OVER
  } state_t;

  localparam logic [7:0] TIMER_LAST  = 8'(TIMEOUT_TICKS - 1);
  localparam logic [7:0] ROUNDS_LAST = 8'(ROUNDS);

  state_t             state;
  state_t             state_nxt;
  logic               start_q;
  logic [7:0]         timer;
  logic [7:0]         timer_nxt;
  logic               shot_taken;
  logic               shot_taken_nxt;
  logic               capture;
  logic [4:0]         shot_x_q;
  logic [4:0]         shot_y_q;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_nxt;
  logic [7:0]         round_q;
  logic [7:0]         round_nxt;
  logic               start_edge;
  logic               hit_calc;

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] val,
                                                  input logic inc);
    if (inc && (val != {SCORE_W{1'b1}}))
      return val + {{(SCORE_W-1){1'b0}}, 1'b1};
    return val;
  endfunction

`ifdef HIT_TOLERANCE_EN
  // X distance taken in 6-bit signed space so column 0 and column 31 stay far apart.
  function automatic logic coord_match(input logic [4:0] sx, input logic [4:0] sy,
                                       input logic [4:0] tx, input logic [4:0] ty);
    logic signed [5:0] dx;
    dx = $signed({1'b0, sx}) - $signed({1'b0, tx});
    return (sy == ty) && ((dx == 6'sd0) || (dx == 6'sd1) || (dx == -6'sd1));
  endfunction
`else
  function automatic logic coord_match(input logic [4:0] sx, input logic [4:0] sy,
                                       input logic [4:0] tx, input logic [4:0] ty);
    return (sx == tx) && (sy == ty);
  endfunction
`endif

  assign start_edge = start_btn & ~start_q;
  assign hit_calc   = shot_taken & coord_match(shot_x_q, shot_y_q, target_x, target_y);

  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    shot_taken_nxt = shot_taken;
    capture        = 1'b0;
    score_nxt      = score_q;
    round_nxt      = round_q;
    case (state)
      IDLE, OVER: begin
        if (start_edge) begin
          score_nxt = '0;
          round_nxt = '0;
          state_nxt = LOAD;
        end
      end
      LOAD: state_nxt = SETTLE;
      SETTLE: begin
        timer_nxt      = '0;
        shot_taken_nxt = 1'b0;
        state_nxt      = AIM;
      end
      AIM: begin
        // A shot in the same cycle as a tick takes priority and freezes the timer.
        if (shot_fire) begin
          capture        = 1'b1;
          shot_taken_nxt = 1'b1;
          state_nxt      = JUDGE;
        end else if (tick) begin
          timer_nxt = timer + 8'd1;
          if (timer == TIMER_LAST) begin
            shot_taken_nxt = 1'b0;
            state_nxt      = JUDGE;
          end
        end
      end
      JUDGE: begin
        round_nxt = round_q + 8'd1;
        score_nxt = sat_inc(score_q, hit_calc);
        state_nxt = (round_nxt == ROUNDS_LAST) ? OVER : LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      timer      <= '0;
      shot_taken <= 1'b0;
      shot_x_q   <= '0;
      shot_y_q   <= '0;
      score_q    <= '0;
      round_q    <= '0;
    end else if (ena) begin
      state      <= state_nxt;
      start_q    <= start_btn;
      timer      <= timer_nxt;
      shot_taken <= shot_taken_nxt;
      score_q    <= score_nxt;
      round_q    <= round_nxt;
      if (capture) begin
        shot_x_q <= shot_x;
        shot_y_q <= shot_y;
      end
    end
  end

  assign start_new_game = ena & (state == LOAD);
  assign result_valid   = ena & (state == JUDGE);
  assign hit            = result_valid & hit_calc;
  assign score          = score_q;
  assign round_cnt      = round_q;
  assign busy           = (state == LOAD) || (state == SETTLE) || (state == AIM) || (state == JUDGE);
  assign game_over      = (state == OVER);

endmodule

// File: tb/tb_game_round_ctrl.sv
// Scoreboard bench for game_round_ctrl: stimulus queues expected judgements, a monitor checks them.
module tb_game_round_ctrl;

  logic       clk;
  logic       reset;
  logic       ena;
  logic       start_btn;
  logic       tick;
  logic       shot_fire;
  logic [4:0] shot_x;
  logic [4:0] shot_y;
  logic [4:0] target_x;
  logic [4:0] target_y;
  logic       start_new_game;
  logic       result_valid;
  logic       hit;
  logic [7:0] score;
  logic [7:0] round_cnt;
  logic       busy;
  logic       game_over;

`ifdef HIT_TOLERANCE_EN
  localparam logic TOL = 1'b1;
`else
  localparam logic TOL = 1'b0;
`endif

  typedef struct {
    logic hit;
    int   score_before;
    int   score_after;
    int   round_after;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_score = 0;
  int   exp_round = 0;

  game_round_ctrl #(.ROUNDS(8), .TIMEOUT_TICKS(15), .SCORE_W(8)) dut (
    .clk(clk), .reset(reset), .ena(ena), .start_btn(start_btn), .tick(tick),
    .shot_fire(shot_fire), .shot_x(shot_x), .shot_y(shot_y),
    .target_x(target_x), .target_y(target_y), .start_new_game(start_new_game),
    .result_valid(result_valid), .hit(hit), .score(score), .round_cnt(round_cnt),
    .busy(busy), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic h);
    exp_t e;
    e.hit          = h;
    e.score_before = exp_score;
    exp_score      = exp_score + (h ? 1 : 0);
    exp_round      = exp_round + 1;
    e.score_after  = exp_score;
    e.round_after  = exp_round;
    exp_q.push_back(e);
  endtask

  task automatic start_game();
    start_btn = 1'b1;
    cyc();
    chk("start_pulse", start_new_game, 1);
    chk("start_busy", busy, 1);
    chk("start_score_clr", score, 0);
    chk("start_round_clr", round_cnt, 0);
    start_btn = 1'b0;
    exp_score = 0;
    exp_round = 0;
    cyc();
    chk("start_pulse_single", start_new_game, 0);
    cyc();
  endtask

  // Entered with the judgement-causing inputs already driven; leaves the DUT in AIM or OVER.
  task automatic finish_round(input logic stray);
    cyc();
    shot_fire = 1'b0;
    tick      = 1'b0;
    cyc();
    if (exp_round < 8) begin
      chk("reload_pulse", start_new_game, 1);
      cyc();
      chk("settle_no_pulse", start_new_game, 0);
      shot_fire = stray;
      cyc();
      shot_fire = 1'b0;
    end else begin
      chk("over_flag", game_over, 1);
      chk("over_not_busy", busy, 0);
    end
  endtask

  task automatic shoot(input logic [4:0] tx, input logic [4:0] ty,
                       input logic [4:0] sx, input logic [4:0] sy,
                       input logic h, input logic with_tick, input logic stray);
    target_x  = tx;
    target_y  = ty;
    shot_x    = sx;
    shot_y    = sy;
    shot_fire = 1'b1;
    tick      = with_tick;
    push_exp(h);
    finish_round(stray);
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
  endtask

  // Monitor: every result_valid must match the oldest queued judgement.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (result_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: result_valid=1 with nothing expected at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("judge_hit", hit, e.hit);
          chk("judge_score_before", score, e.score_before);
          @(negedge clk);
          chk("score_after", score, e.score_after);
          chk("round_after", round_cnt, e.round_after);
        end
      end else if (hit !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL hit_without_valid: hit=%0d expected 0 at %0t", hit, $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; ena = 1'b1; start_btn = 1'b0; tick = 1'b0; shot_fire = 1'b0;
    shot_x = '0; shot_y = '0; target_x = '0; target_y = '0;
    cyc(); cyc();
    chk("rst_busy", busy, 0);
    chk("rst_over", game_over, 0);
    chk("rst_pulse", start_new_game, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_score", score, 0);
    chk("rst_round", round_cnt, 0);
    reset = 1'b0;
    shot_fire = 1'b1;
    cyc();
    shot_fire = 1'b0;
    chk("idle_shot_ignored", busy, 0);
    cyc();

    // Game 1: mixed rounds.
    start_game();
    shoot(5'd12, 5'd30, 5'd12, 5'd30, 1'b1, 1'b0, 1'b0);
    target_x = 5'd12; target_y = 5'd30;
    tick_n(14);
    push_exp(1'b0);
    tick = 1'b1;
    finish_round(1'b0);
    tick_n(14);
    shoot(5'd3, 5'd31, 5'd3, 5'd31, 1'b1, 1'b1, 1'b1);
    shoot(5'd5, 5'd5, 5'd6, 5'd5, TOL, 1'b0, 1'b0);
    shoot(5'd31, 5'd7, 5'd0, 5'd7, 1'b0, 1'b0, 1'b0);
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1; shot_fire = (i == 2); shot_x = 5'd9; shot_y = 5'd9;
      cyc();
      chk("freeze_pulse", start_new_game, 0);
      chk("freeze_valid", result_valid, 0);
      chk("freeze_busy", busy, 1);
      chk("freeze_score", score, exp_score);
    end
    ena = 1'b1; tick = 1'b0; shot_fire = 1'b0;
    tick_n(14);
    shoot(5'd9, 5'd9, 5'd9, 5'd9, 1'b1, 1'b0, 1'b0);
    start_btn = 1'b1;
    cyc();
    chk("aim_start_ignored", start_new_game, 0);
    start_btn = 1'b0;
    cyc();
    chk("aim_start_ignored2", start_new_game, 0);
    chk("aim_still_busy", busy, 1);
    shoot(5'd1, 5'd3, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0);
    shoot(5'd20, 5'd10, 5'd20, 5'd10, 1'b1, 1'b0, 1'b0);
    chk("game1_score", score, TOL ? 5 : 4);
    chk("game1_round", round_cnt, 8);

    // Game 2: all hits.
    cyc();
    start_game();
    for (int i = 0; i < 8; i++)
      shoot(5'(i + 2), 5'(i * 3), 5'(i + 2), 5'(i * 3), 1'b1, 1'b0, 1'b0);
    cyc();
    chk("game2_over", game_over, 1);
    chk("game2_score", score, 8);
    chk("game2_round", round_cnt, 8);

    // Game 3: restart from OVER, then async reset mid-round.
    start_game();
    shoot(5'd4, 5'd4, 5'd4, 5'd4, 1'b1, 1'b0, 1'b0);
    chk("pre_reset_score", score, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_busy", busy, 0);
    chk("async_over", game_over, 0);
    chk("async_pulse", start_new_game, 0);
    chk("async_valid", result_valid, 0);
    chk("async_score", score, 0);
    chk("async_round", round_cnt, 0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("post_reset_idle", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
Round sequencer for the shooting game. It owns the game flow: it detects the start button, pulses `start_new_game` into the target generator, and waits one settle cycle for the new target. It then waits for a shot or a timeout, judges hit/miss against the current target, scores it, and ends the game after a fixed number of rounds. It sits between the user-input/tick logic and the target generator and scoreboard.

Parameters:
ROUNDS, 8, rounds per game (1..255)
TIMEOUT_TICKS, 15, tick pulses allowed in AIM before an automatic miss (1..255)
SCORE_W, 8, score counter width

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
ena  input  1  global enable; low freezes all state
start_btn  input  1  level start button, synchronised upstream
tick  input  1  one-cycle timing pulse
shot_fire  input  1  one-cycle shot strobe
shot_x  input  5  shot X coordinate
shot_y  input  5  shot Y coordinate
target_x  input  5  current target X from target generator
target_y  input  5  current target Y from target generator
start_new_game  output  1  one-cycle pulse to target generator enable
result_valid  output  1  one-cycle pulse, judgement available
hit  output  1  judgement, valid only with result_valid, 0 otherwise
score  output  SCORE_W  hits this game, saturating
round_cnt  output  8  rounds completed this game
busy  output  1  high in LOAD/SETTLE/AIM/JUDGE
game_over  output  1  high in OVER

Behaviour:
- Reset (async, active-high): state IDLE. All outputs 0, timer 0, start_q 0, captured shot 0.
- ena=0: state, counters, timer and start_q hold. start_new_game, result_valid and hit are forced 0.
- Start edge: start_btn & ~start_q. start_q is registered every enabled cycle.
- States: IDLE, LOAD, SETTLE, AIM, JUDGE, OVER. All outputs decode from registered state/counters.
- IDLE: on start edge, clear score and round_cnt, then go to LOAD.
- LOAD: start_new_game=1 for exactly one cycle; next state is SETTLE.
- SETTLE: one cycle so the target registers update. Clear timer; go to AIM.
- AIM:
  - shot_fire: capture shot_x/shot_y, mark shot taken, go to JUDGE.
  - Else on tick: increment timer. If timer==TIMEOUT_TICKS-1, mark timeout and go to JUDGE.
  - shot_fire and tick in the same cycle: the shot wins and the timer does not increment.
- JUDGE (one cycle): result_valid=1.
  - hit=1 iff a shot was taken and the captured coordinates match target_x/target_y exactly.
  - Timeout always gives hit=0.
  - At the end of the cycle: round_cnt+1; score+1 on hit, saturating at all-ones.
  - Next state is OVER if the new round_cnt==ROUNDS, else LOAD.
- OVER: game_over=1. A start edge clears score and round_cnt and goes to LOAD. score stays readable until then.
- shot_fire outside AIM is ignored. start edges outside IDLE/OVER are ignored.
- Latency:
  - start edge sampled in cycle N → start_new_game in N+1 → AIM from N+3.
  - shot sampled in cycle M → result_valid in M+1 → updated score visible in M+2.
- Reset mid-round aborts immediately to IDLE; no result_valid is emitted.

Optional Feature:
HIT_TOLERANCE_EN
- Defined: hit when shot_y==target_y and |shot_x−target_x|≤1. The difference uses 6-bit signed arithmetic with no wrap: X=0 vs 31 is a miss.
- Undefined: exact coordinate match only.

Test Plan:
- Reset then start_btn rising edge → start_new_game is high for exactly 1 cycle, 1 cycle after the edge is sampled; busy=1; score=0, round_cnt=0.
- Target (12,30), shot (12,30) in AIM → result_valid=1 and hit=1 next cycle; score=1, round_cnt=1; new start_new_game pulse 1 cycle after JUDGE.
- No shot with TIMEOUT_TICKS=15 → the 15th tick gives result_valid=1 and hit=0; score unchanged.
- shot_fire and tick in the same cycle as the last timeout tick, shot (3,31) = target → hit=1, not a timeout miss.
- ROUNDS=8, all hits → after the 8th JUDGE, game_over=1, score=8, round_cnt=8. A start edge clears both to 0 and pulses start_new_game.
- ena=0 held 5 cycles in AIM with ticks and a shot → no state change, no pulses; resumes correctly when ena=1. Async reset asserted in AIM → IDLE with all outputs 0 in the same cycle.
